// File: rtl/seg_capture_pkg.sv
// Shared types and constants for the seven-segment data capture block.
// Page indices, byte-lane width and the page-advance helper.
package seg_capture_pkg;

   localparam int PAGE_COUNT = 4;
   localparam int BYTE_W     = 8;
   localparam int WORD_W     = 32;
   localparam int LANES      = WORD_W / BYTE_W;

   typedef enum logic [1:0] {
      PG_MMIO  = 2'd0,
      PG_PC    = 2'd1,
      PG_INSTR = 2'd2,
      PG_ALU   = 2'd3
   } page_t;

   // Wraps 3->0 by 2-bit truncation.
   function automatic page_t page_next(input page_t p);
      logic [1:0] n;
      n = p + 2'd1;
      return page_t'(n);
   endfunction

endpackage

// File: rtl/btn_debounce.sv
// Raw active-low key -> 2-FF sync -> stable-level debouncer.
// press_pulse is high for the one cycle whose edge takes stable 1->0.
module btn_debounce #(
   parameter int DEBOUNCE_CYCLES = 250000
) (
   input  logic clk,
   input  logic rst_n,
   input  logic raw_n,
   output logic press_pulse
);

   localparam int CW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
   localparam logic [CW-1:0] LAST = CW'(DEBOUNCE_CYCLES - 1);

   logic          sync1;
   logic          sync2;
   logic          stable;
   logic [CW-1:0] cnt;
   logic          diff;
   logic          hit;

   assign diff = sync2 != stable;
   assign hit  = diff && (cnt == LAST);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sync1  <= 1'b1;
         sync2  <= 1'b1;
         stable <= 1'b1;
         cnt    <= '0;
      end else begin
         sync1 <= raw_n;
         sync2 <= sync1;
         if (!diff) begin
            cnt <= '0;
         end else if (hit) begin
            stable <= sync2;
            cnt    <= '0;
         end else begin
            cnt <= cnt + 1'b1;
         end
      end
   end

   // Release (0->1) deliberately produces nothing.
   assign press_pulse = hit && !sync2;

endmodule

// File: rtl/seg_data_capture.sv
// Page-selected, rate-limited 32-bit feeder for the 8-digit display.
// Optional SEG_CAPTURE_PAGE_TAG_EN puts {2'b00,page} in data[31:28].
module seg_data_capture
   import seg_capture_pkg::*;
#(
   parameter int DEBOUNCE_CYCLES = 250000,
   parameter int REFRESH_CYCLES  = 2500000
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        btn_next_n,
   input  logic        freeze,
   input  logic        mmio_we,
   input  logic [3:0]  mmio_be,
   input  logic [31:0] mmio_wdata,
   input  logic [31:0] dbg_pc,
   input  logic [31:0] dbg_instr,
   input  logic [31:0] dbg_alu,
   output logic [31:0] data,
   output logic [1:0]  page,
   output logic        upd
);

   localparam int RW = (REFRESH_CYCLES > 1) ? $clog2(REFRESH_CYCLES) : 1;
   localparam logic [RW-1:0] RLAST = RW'(REFRESH_CYCLES - 1);

   logic          press;
   logic          tick;
   logic          capture;
   logic          frz1;
   logic          frz2;
   logic [RW-1:0] rcnt;
   logic [31:0]   mmio;
   logic [31:0]   src;
   logic [31:0]   cap_word;
   page_t         page_q;
   page_t         page_d;

   btn_debounce #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
   ) u_btn (
      .clk        (clk),
      .rst_n      (rst_n),
      .raw_n      (btn_next_n),
      .press_pulse(press)
   );

   assign tick    = rcnt == RLAST;
   assign capture = tick || press;

   always_comb begin
      page_d = page_q;
      if (press) page_d = page_next(page_q);
   end

   // Select on the next page so a press shows its page at once.
   always_comb begin
      src = mmio;
      unique case (page_d)
         PG_MMIO:  src = mmio;
         PG_PC:    src = dbg_pc;
         PG_INSTR: src = dbg_instr;
         PG_ALU:   src = dbg_alu;
      endcase
   end

`ifdef SEG_CAPTURE_PAGE_TAG_EN
   assign cap_word = {2'b00, page_d, src[27:0]};
`else
   assign cap_word = src;
`endif

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         frz1 <= 1'b0;
         frz2 <= 1'b0;
      end else begin
         frz1 <= freeze;
         frz2 <= frz1;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         mmio <= '0;
      end else if (mmio_we) begin
         for (int i = 0; i < LANES; i++) begin
            if (mmio_be[i])
               mmio[i*BYTE_W +: BYTE_W] <= mmio_wdata[i*BYTE_W +: BYTE_W];
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rcnt <= '0;
      end else if (tick) begin
         rcnt <= '0;
      end else begin
         rcnt <= rcnt + 1'b1;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         page_q <= PG_MMIO;
      end else begin
         page_q <= page_d;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         data <= '0;
         upd  <= 1'b0;
      end else if (capture && !frz2) begin
         data <= cap_word;
         upd  <= 1'b1;
      end else begin
         upd  <= 1'b0;
      end
   end

   assign page = page_q;

endmodule

// File: tb/tb_seg_data_capture.sv
// Directed bench for seg_data_capture, DEBOUNCE_CYCLES=4, REFRESH_CYCLES=8.
// Inputs driven and outputs sampled on the falling clock edge.
module tb_seg_data_capture;

   localparam logic [31:0] PC0   = 32'h0040_0010;
   localparam logic [31:0] PC1   = 32'h0040_0020;
   localparam logic [31:0] INSTR = 32'h1234_5678;
   localparam logic [31:0] ALU   = 32'hDEAD_BEEF;
   localparam logic [31:0] MREG  = 32'h00BB_00DD;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        btn_next_n;
   logic        freeze;
   logic        mmio_we;
   logic [3:0]  mmio_be;
   logic [31:0] mmio_wdata;
   logic [31:0] dbg_pc;
   logic [31:0] dbg_instr;
   logic [31:0] dbg_alu;
   logic [31:0] data;
   logic [1:0]  page;
   logic        upd;

   int nvec = 0;
   int nerr = 0;
   int cyc;

   seg_data_capture #(
      .DEBOUNCE_CYCLES(4),
      .REFRESH_CYCLES (8)
   ) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .btn_next_n(btn_next_n),
      .freeze    (freeze),
      .mmio_we   (mmio_we),
      .mmio_be   (mmio_be),
      .mmio_wdata(mmio_wdata),
      .dbg_pc    (dbg_pc),
      .dbg_instr (dbg_instr),
      .dbg_alu   (dbg_alu),
      .data      (data),
      .page      (page),
      .upd       (upd)
   );

   always #5 clk = ~clk;

   // Posedges since reset release; refresh ticks capture when cyc%8==0.
   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) cyc <= 0;
      else        cyc <= cyc + 1;
   end

   task automatic check(input string tag, input logic [31:0] got,
                        input logic [31:0] exp);
      nvec++;
      if (got !== exp) begin
         nerr++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   task automatic step(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic wait_upd(input string tag);
      int n;
      n = 0;
      do begin
         step(1);
         n++;
      end while (!upd && n < 20);
      check(tag, {31'd0, upd}, 32'd1);
   endtask

   task automatic press_key();
      btn_next_n = 1'b0;
      step(10);
      btn_next_n = 1'b1;
      step(8);
   endtask

   initial begin
      int n;
      int guard;
      logic [1:0] pg;

      rst_n      = 1'b0;
      btn_next_n = 1'b0;
      freeze     = 1'b1;
      mmio_we    = 1'b1;
      mmio_be    = 4'hF;
      mmio_wdata = 32'hFFFF_FFFF;
      dbg_pc     = PC0;
      dbg_instr  = INSTR;
      dbg_alu    = ALU;
      step(3);
      check("rst_data", data, 32'd0);
      check("rst_page", {30'd0, page}, 32'd0);
      check("rst_upd", {31'd0, upd}, 32'd0);

      btn_next_n = 1'b1;
      freeze     = 1'b0;
      mmio_we    = 1'b0;
      mmio_be    = 4'h0;
      mmio_wdata = 32'd0;
      step(1);
      rst_n = 1'b1;
      step(7);
      check("pre_tick_upd", {31'd0, upd}, 32'd0);
      step(1);
      check("tick8_upd", {31'd0, upd}, 32'd1);
      check("tick8_data", data, 32'd0);
      step(1);
      check("upd_one_cycle", {31'd0, upd}, 32'd0);

      // Byte-enabled MMIO write, then a be=0 no-op write.
      mmio_we    = 1'b1;
      mmio_be    = 4'b0101;
      mmio_wdata = 32'hAABB_CCDD;
      step(1);
      mmio_we = 1'b0;
      wait_upd("mmio_cap_upd");
      check("mmio_be_data", data, MREG);
      mmio_we    = 1'b1;
      mmio_be    = 4'b0000;
      mmio_wdata = 32'hFFFF_FFFF;
      step(1);
      mmio_we = 1'b0;
      wait_upd("noop_cap_upd");
      check("mmio_be0_data", data, MREG);

      // Short glitch rejected, then one real press.
      btn_next_n = 1'b0;
      step(2);
      btn_next_n = 1'b1;
      step(6);
      check("glitch_page", {30'd0, page}, 32'd0);
      btn_next_n = 1'b0;
      step(5);
      check("pre_press_page", {30'd0, page}, 32'd0);
      step(1);
      check("press_page", {30'd0, page}, 32'd1);
      check("press_data", data, PC0);
      check("press_upd", {31'd0, upd}, 32'd1);
      step(4);
      btn_next_n = 1'b1;
      step(8);
      check("release_page", {30'd0, page}, 32'd1);

      press_key();
      check("p2_page", {30'd0, page}, 32'd2);
      check("p2_data", data, INSTR);
      press_key();
      check("p3_page", {30'd0, page}, 32'd3);
      check("p3_data", data, ALU);
      press_key();
      check("p0_page", {30'd0, page}, 32'd0);
      check("p0_data", data, MREG);
      press_key();
      check("p1_page", {30'd0, page}, 32'd1);
      check("p1_data", data, PC0);

      // Freeze holds data across several ticks.
      freeze = 1'b1;
      step(3);
      dbg_pc = PC1;
      n = 0;
      for (int i = 0; i < 30; i++) begin
         step(1);
         if (upd) n++;
      end
      check("frz_upd_cnt", n, 32'd0);
      check("frz_data", data, PC0);
      freeze = 1'b0;
      wait_upd("unfrz_upd");
      check("unfrz_data", data, PC1);

      // Page advances while frozen; data waits for unfreeze.
      freeze = 1'b1;
      step(3);
      press_key();
      check("frz_press_page", {30'd0, page}, 32'd2);
      check("frz_press_data", data, PC1);
      freeze = 1'b0;
      wait_upd("unfrz2_upd");
      check("unfrz2_data", data, INSTR);

      // Align the press capture edge with a refresh tick.
      guard = 0;
      while (((cyc + 6) % 8) != 0 && guard < 10) begin
         step(1);
         guard++;
      end
      pg = page;
      n = 0;
      btn_next_n = 1'b0;
      for (int i = 0; i < 10; i++) begin
         step(1);
         if (upd) n++;
      end
      btn_next_n = 1'b1;
      step(8);
      check("coinc_upd_cnt", n, 32'd1);
      check("coinc_page", {30'd0, page}, {30'd0, pg} + 32'd1);
      check("coinc_data", data, ALU);

      // Reset in the middle of debouncing a press.
      btn_next_n = 1'b0;
      step(4);
      rst_n = 1'b0;
      #1;
      check("amid_rst_page", {30'd0, page}, 32'd0);
      check("amid_rst_data", data, 32'd0);
      check("amid_rst_upd", {31'd0, upd}, 32'd0);
      btn_next_n = 1'b1;
      step(2);
      rst_n = 1'b1;
      step(12);
      check("post_rst_page", {30'd0, page}, 32'd0);
      check("post_rst_data", data, 32'd0);

      $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1);
   end

endmodule
